// File: rtl/gamepad_param_ctrl.sv
// Gamepad-driven render parameter controller.
// Samples the buttons once per frame (frame_tick) and turns them into camera
// position, render level and render mode. Directions auto-repeat; A/B/Select/
// Start act on rising edges only.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   frame_tick            - one-cycle pulse per video frame
//   btn_*                 - decoded button levels, 1 = pressed
//   is_present            - controller connected; 0 forces all buttons released
//   cam_x, cam_y          - camera coordinates, saturating at 0 / X_MAX / Y_MAX
//   level, mode           - render level (wraps mod 4) and render mode flag
//   params_changed        - one-cycle pulse when any parameter output changed
module gamepad_param_ctrl #(
    parameter int unsigned STEP         = 4,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned X_INIT       = 320,
    parameter int unsigned Y_INIT       = 240,
    parameter int unsigned REPEAT_DELAY = 30,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_start,
    input  logic       btn_select,
    input  logic       is_present,
    output logic [9:0] cam_x,
    output logic [9:0] cam_y,
    output logic [1:0] level,
    output logic       mode,
    output logic       params_changed
);

    localparam int unsigned NDIR = 4;
    // Direction indices
    localparam int unsigned D_UP    = 0;
    localparam int unsigned D_DOWN  = 1;
    localparam int unsigned D_LEFT  = 2;
    localparam int unsigned D_RIGHT = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [1:0] state_q [NDIR];
    logic [1:0] state_d [NDIR];
    logic [7:0] cnt_q   [NDIR];
    logic [7:0] cnt_d   [NDIR];

    logic [9:0] cam_x_q, cam_x_d;
    logic [9:0] cam_y_q, cam_y_d;
    logic [1:0] level_q, level_d;
    logic       mode_q, mode_d;
    logic       changed_q, changed_d;

    // Previous-sample registers for the edge-triggered buttons
    logic a_q, b_q, start_q, select_q;

    logic [NDIR-1:0] press_c;
    logic [NDIR-1:0] step_c;
    logic a_c, b_c, start_c, select_c;
    logic a_edge_c, b_edge_c, start_edge_c, select_edge_c;
    logic [10:0] x_ext_c, y_ext_c, sum_c;

    // Effective button levels: absent controller reads as all released;
    // opposing directions pressed together cancel each other.
    always_comb begin
        press_c[D_UP]    = is_present & btn_up    & ~btn_down;
        press_c[D_DOWN]  = is_present & btn_down  & ~btn_up;
        press_c[D_LEFT]  = is_present & btn_left  & ~btn_right;
        press_c[D_RIGHT] = is_present & btn_right & ~btn_left;
        a_c              = is_present & btn_a;
        b_c              = is_present & btn_b;
        start_c          = is_present & btn_start;
        select_c         = is_present & btn_select;
        a_edge_c         = frame_tick & a_c      & ~a_q;
        b_edge_c         = frame_tick & b_c      & ~b_q;
        start_edge_c     = frame_tick & start_c  & ~start_q;
        select_edge_c    = frame_tick & select_c & ~select_q;
    end

    // Per-direction auto-repeat FSMs
    always_comb begin
        for (int i = 0; i < NDIR; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            step_c[i]  = 1'b0;
            if (frame_tick) begin
                if (start_edge_c || !press_c[i]) begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = 8'd0;
                end else begin
                    case (state_q[i])
                        S_IDLE: begin
                            step_c[i]  = 1'b1;
                            cnt_d[i]   = 8'd0;
                            state_d[i] = S_DELAY;
                        end
                        S_DELAY: begin
                            if (cnt_q[i] + 8'd1 == 8'(REPEAT_DELAY)) begin
                                step_c[i]  = 1'b1;
                                cnt_d[i]   = 8'd0;
                                state_d[i] = S_REPEAT;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 8'd1;
                            end
                        end
                        S_REPEAT: begin
                            if (cnt_q[i] + 8'd1 == 8'(REPEAT_RATE)) begin
                                step_c[i] = 1'b1;
                                cnt_d[i]  = 8'd0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 8'd1;
                            end
                        end
                        default: begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Parameter updates; Start overrides everything else on the same tick
    always_comb begin
        cam_x_d = cam_x_q;
        cam_y_d = cam_y_q;
        level_d = level_q;
        mode_d  = mode_q;
        x_ext_c = {1'b0, cam_x_q};
        y_ext_c = {1'b0, cam_y_q};
        sum_c   = 11'd0;

        if (step_c[D_RIGHT]) begin
            sum_c   = x_ext_c + 11'(STEP);
            cam_x_d = (sum_c > 11'(X_MAX)) ? 10'(X_MAX) : sum_c[9:0];
        end else if (step_c[D_LEFT]) begin
            cam_x_d = (x_ext_c < 11'(STEP)) ? 10'd0 : 10'(x_ext_c - 11'(STEP));
        end

        if (step_c[D_DOWN]) begin
            sum_c   = y_ext_c + 11'(STEP);
            cam_y_d = (sum_c > 11'(Y_MAX)) ? 10'(Y_MAX) : sum_c[9:0];
        end else if (step_c[D_UP]) begin
            cam_y_d = (y_ext_c < 11'(STEP)) ? 10'd0 : 10'(y_ext_c - 11'(STEP));
        end

        if (a_edge_c && !b_edge_c) begin
            level_d = level_q + 2'd1;
        end else if (b_edge_c && !a_edge_c) begin
            level_d = level_q - 2'd1;
        end

        if (select_edge_c) begin
            mode_d = ~mode_q;
        end

        if (start_edge_c) begin
            cam_x_d = 10'(X_INIT);
            cam_y_d = 10'(Y_INIT);
            level_d = 2'd0;
            mode_d  = 1'b0;
        end

        changed_d = (cam_x_d != cam_x_q) || (cam_y_d != cam_y_q) ||
                    (level_d != level_q) || (mode_d != mode_q);
    end

    // State registers; parameters move only on frame ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDIR; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= 8'd0;
            end
            cam_x_q   <= 10'(X_INIT);
            cam_y_q   <= 10'(Y_INIT);
            level_q   <= 2'd0;
            mode_q    <= 1'b0;
            changed_q <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            start_q   <= 1'b0;
            select_q  <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (frame_tick) begin
                for (int i = 0; i < NDIR; i++) begin
                    state_q[i] <= state_d[i];
                    cnt_q[i]   <= cnt_d[i];
                end
                cam_x_q   <= cam_x_d;
                cam_y_q   <= cam_y_d;
                level_q   <= level_d;
                mode_q    <= mode_d;
                changed_q <= changed_d;
                a_q       <= a_c;
                b_q       <= b_c;
                start_q   <= start_c;
                select_q  <= select_c;
            end
        end
    end

    assign cam_x          = cam_x_q;
    assign cam_y          = cam_y_q;
    assign level          = level_q;
    assign mode           = mode_q;
    assign params_changed = changed_q;

endmodule

// File: tb/tb_gamepad_param_ctrl.sv
// Directed self-checking bench for gamepad_param_ctrl (default parameters).
module tb_gamepad_param_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_start = 1'b0, btn_select = 1'b0;
    logic       is_present = 1'b1;
    logic [9:0] cam_x, cam_y;
    logic [1:0] level;
    logic       mode;
    logic       params_changed;

    int n_chk  = 0;
    int n_fail = 0;
    int pc_cnt = 0;

    gamepad_param_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_a         (btn_a),
        .btn_b         (btn_b),
        .btn_start     (btn_start),
        .btn_select    (btn_select),
        .is_present    (is_present),
        .cam_x         (cam_x),
        .cam_y         (cam_y),
        .level         (level),
        .mode          (mode),
        .params_changed(params_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; outputs sampled on the following falling edge
    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        if (params_changed === 1'b1) pc_cnt++;
    endtask

    task automatic release_all();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_a = 0; btn_b = 0; btn_start = 0; btn_select = 0;
        is_present = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1; frame_tick = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        pc_cnt = 0;
    endtask

    task automatic press_right(input int n);
        for (int i = 0; i < n; i++) begin
            btn_right = 1'b1; tick();
            btn_right = 1'b0; tick();
        end
    endtask

    initial begin
        // Reset state
        release_all();
        do_reset();
        chk("rst_cam_x", 32'(cam_x), 320);
        chk("rst_cam_y", 32'(cam_y), 240);
        chk("rst_level", 32'(level), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_pc", 32'(params_changed), 0);

        // Right held 43 ticks: steps at f0, f30, f36, f42
        btn_right = 1'b1;
        for (int t = 0; t <= 42; t++) begin
            tick();
            if (t == 0)  chk("hold_f0", 32'(cam_x), 324);
            if (t == 29) chk("hold_f29", 32'(cam_x), 324);
            if (t == 30) chk("hold_f30", 32'(cam_x), 328);
            if (t == 35) chk("hold_f35", 32'(cam_x), 328);
            if (t == 36) chk("hold_f36", 32'(cam_x), 332);
            if (t == 42) chk("hold_f42", 32'(cam_x), 336);
        end
        chk("hold_pulses", 32'(pc_cnt), 4);
        btn_right = 1'b0;
        tick();
        // Button activity between ticks is ignored
        btn_left = 1'b1;
        repeat (5) @(negedge clk);
        btn_left = 1'b0;
        chk("between_ticks", 32'(cam_x), 336);
        tick();
        chk("left_glitch_ignored", 32'(cam_x), 336);

        // Right saturation at X_MAX
        release_all();
        do_reset();
        press_right(79);
        chk("sat_pre", 32'(cam_x), 636);
        btn_right = 1'b1; tick();
        chk("sat_x1", 32'(cam_x), 639);
        chk("sat_pc1", 32'(params_changed), 1);
        btn_right = 1'b0; tick();
        btn_right = 1'b1; tick();
        chk("sat_x2", 32'(cam_x), 639);
        chk("sat_pc2", 32'(params_changed), 0);
        btn_right = 1'b0; tick();

        // Left+right cancel; left alone afterwards is a fresh press
        release_all();
        do_reset();
        btn_left = 1'b1; btn_right = 1'b1;
        repeat (40) tick();
        chk("lr_cancel_x", 32'(cam_x), 320);
        chk("lr_cancel_pc", 32'(pc_cnt), 0);
        btn_right = 1'b0; tick();
        chk("lr_left_after", 32'(cam_x), 316);

        // Up saturation at 0
        release_all();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            btn_up = 1'b1; tick();
            btn_up = 1'b0; tick();
        end
        chk("up_zero", 32'(cam_y), 0);
        btn_up = 1'b1; tick();
        chk("up_sat_y", 32'(cam_y), 0);
        chk("up_sat_pc", 32'(params_changed), 0);

        // Level and mode
        release_all();
        do_reset();
        btn_b = 1'b1; tick();
        chk("b_wrap", 32'(level), 3);
        btn_b = 1'b0; tick();
        btn_a = 1'b1; btn_b = 1'b1; tick();
        chk("ab_same", 32'(level), 3);
        btn_a = 1'b0; btn_b = 1'b0; tick();
        btn_a = 1'b1; tick();
        chk("a_wrap", 32'(level), 0);
        pc_cnt = 0;
        repeat (49) tick();
        chk("a_no_repeat", 32'(level), 0);
        chk("a_no_repeat_pc", 32'(pc_cnt), 0);
        btn_a = 1'b0;
        btn_select = 1'b1; tick();
        chk("sel_toggle", 32'(mode), 1);

        // Start overrides a simultaneous step
        release_all();
        do_reset();
        press_right(20);
        btn_a = 1'b1; tick(); btn_a = 1'b0; tick();
        btn_a = 1'b1; tick(); btn_a = 1'b0; tick();
        btn_select = 1'b1; tick(); btn_select = 1'b0; tick();
        chk("pre_start_x", 32'(cam_x), 400);
        chk("pre_start_lvl", 32'(level), 2);
        chk("pre_start_mode", 32'(mode), 1);
        btn_start = 1'b1; btn_right = 1'b1; tick();
        chk("start_x", 32'(cam_x), 320);
        chk("start_y", 32'(cam_y), 240);
        chk("start_lvl", 32'(level), 0);
        chk("start_mode", 32'(mode), 0);
        chk("start_pc", 32'(params_changed), 1);

        // Controller unplugged mid-hold
        release_all();
        do_reset();
        btn_down = 1'b1; tick();
        chk("down_f0", 32'(cam_y), 244);
        repeat (5) tick();
        is_present = 1'b0; tick();
        chk("absent_y", 32'(cam_y), 244);
        chk("absent_pc", 32'(params_changed), 0);
        repeat (30) tick();
        chk("absent_hold_y", 32'(cam_y), 244);
        is_present = 1'b1; tick();
        chk("replug_step", 32'(cam_y), 248);

        // Reset mid-hold; still-held button is a new press
        release_all();
        do_reset();
        btn_right = 1'b1;
        repeat (3) tick();
        chk("prereset_x", 32'(cam_x), 324);
        do_reset();
        chk("midreset_x", 32'(cam_x), 320);
        tick();
        chk("postreset_step", 32'(cam_x), 324);
        release_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
